t_decoder: RTL and testbench
============================

T_DECODER -- requirements
Module: t_decoder

Interface
REQ-001 SHALL have parameter MAX_RUN, default 6: count of consecutive non-toggle samples that raises a run error; legal range 2..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of toggle_cnt.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port q_in, input, 1: T-flip-flop-encoded line level (toggle = 1, hold = 0).
REQ-006 SHALL have port q_valid, input, 1: sample strobe; q_in is sampled only in cycles where q_valid=1.
REQ-007 SHALL have port err_clr, input, 1: clears a latched run error.
REQ-008 SHALL have port t_out, output, 1: recovered T bit.
REQ-009 SHALL have port t_valid, output, 1: one-cycle qualifier for t_out.
REQ-010 SHALL have port run_err, output, 1: sticky error flag for an over-length hold run.
REQ-011 SHALL have port toggle_cnt, output, CNT_W: saturating count of decoded 1s.

Function
REQ-012 SHALL implement FSM states SYNC, RUN, ERR, and SHALL enter SYNC on reset.
REQ-013 In SYNC, on a cycle with q_valid=1, the block SHALL store q_in into q_prev, SHALL go to RUN, and SHALL NOT assert t_valid.
REQ-014 In RUN, on a cycle with q_valid=1, t_out SHALL be q_in XOR q_prev, registered, with t_valid=1 on the next cycle (latency 1); q_prev SHALL then update to q_in.
REQ-015 t_valid SHALL be 0 in every cycle not following an accepted RUN sample; t_out SHALL hold its last value.
REQ-016 The run counter SHALL increment on each decoded 0 and clear on each decoded 1.
REQ-017 When a decoded 0 makes the run count equal MAX_RUN, that bit SHALL still be output with t_valid, run_err SHALL rise on the same cycle as that t_valid, and the FSM SHALL go to ERR.
REQ-018 In ERR, samples SHALL be ignored, t_valid SHALL stay 0, and run_err SHALL stay 1.
REQ-019 In ERR, err_clr=1 SHALL clear run_err and the run count on the next edge and SHALL return the FSM to SYNC.
REQ-020 err_clr SHALL be ignored outside ERR.
REQ-021 If err_clr and q_valid are both 1 in ERR, err_clr SHALL win and the sample SHALL be discarded.
REQ-022 toggle_cnt SHALL increment with each t_out=1 and SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-023 q_valid gaps of any length SHALL NOT advance the run count.

Reset
REQ-024 While rst=1, the block SHALL drive state=SYNC, q_prev=0, t_out=0, t_valid=0, run_err=0, run count=0, and toggle_cnt=0.
REQ-025 rst SHALL take priority over err_clr and q_valid, and mid-stream reset SHALL discard any in-flight bit; the first post-reset sample SHALL be treated as a SYNC sample.

Configuration
REQ-026 With macro T_DECODER_CNT_EN defined, the toggle counter per REQ-022 SHALL be built.
REQ-027 Without T_DECODER_CNT_EN, toggle_cnt SHALL be tied to 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package t_decoder_pkg SHALL hold the FSM state typedef (SYNC/RUN/ERR) and the default constants MAX_RUN_DEF=6 and CNT_W_DEF=8.
REQ-029 One sub-module, t_decoder_run_cnt, SHALL hold the run-length counter with inc/clr inputs and an at-limit output; it SHALL be instantiated once.

Verification
REQ-030 The bench SHALL apply rst for 2 cycles, then q_valid=1 with q_in=1,0,0,1,1 on consecutive cycles, and SHALL check t_out=1,0,1,0 with t_valid on 4 cycles, no t_valid for the first sample, and toggle_cnt=2.
REQ-031 The bench SHALL apply q_in=0 for 7 samples with MAX_RUN=6, and SHALL check run_err=1 together with the 6th decoded 0, then no further t_valid.
REQ-032 The bench SHALL apply err_clr=1 and q_valid=1 in the same cycle in ERR, and SHALL check that the FSM enters SYNC, run_err=0, and the next sample produces no t_valid.
REQ-033 The bench SHALL use CNT_W=3 with 10 alternating samples and SHALL check that toggle_cnt stops at 7; it SHALL then rebuild without T_DECODER_CNT_EN and check that toggle_cnt stays 0 throughout.
REQ-034 The bench SHALL assert rst between the 3rd and 4th samples of a toggling stream, and SHALL check that all outputs are 0 on the next cycle and the following sample is SYNC with no t_valid.
REQ-035 The bench SHALL insert 5-cycle q_valid=0 gaps between 0-samples, and SHALL check the same run count and t_out sequence as the gap-free stream.

Source files
------------

// File: rtl/t_decoder_pkg.sv
// Shared FSM state encoding and default parameters for the T-flip-flop line decoder.
package t_decoder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t SYNC = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t ERR  = 2'd2;

    localparam int MAX_RUN_DEF = 6;
    localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/t_decoder_run_cnt.sv
// Run-length counter of consecutive decoded zeros; flags the increment that reaches MAX_RUN.
module t_decoder_run_cnt
    import t_decoder_pkg::*;
#(
    parameter int MAX_RUN = MAX_RUN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [3:0] LIMIT_M1 = 4'(MAX_RUN - 1);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    // at_limit qualifies the current increment so the caller can react on the same edge
    assign at_limit = inc && (cnt_reg == LIMIT_M1);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = 4'd0;
        end else if (inc && (cnt_reg != 4'hf)) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/t_decoder.sv
// Recovers T bits from a T-flip-flop-encoded line and flags over-length hold runs.
// Optional toggle counter is built only when T_DECODER_CNT_EN is defined.
module t_decoder
    import t_decoder_pkg::*;
#(
    parameter int MAX_RUN = MAX_RUN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             q_valid,
    input  logic             err_clr,
    output logic             t_out,
    output logic             t_valid,
    output logic             run_err,
    output logic [CNT_W-1:0] toggle_cnt
);

    state_t state_reg;
    state_t state_next;
    logic   q_prev_reg;
    logic   t_out_reg;
    logic   t_valid_reg;
    logic   run_err_reg;

    logic accept;
    logic dec_bit;
    logic run_inc;
    logic run_clr;
    logic at_limit;

    assign accept  = (state_reg == RUN) && q_valid;
    assign dec_bit = q_in ^ q_prev_reg;
    assign run_inc = accept && !dec_bit;
    // err_clr outside ERR must not touch the run count
    assign run_clr = (accept && dec_bit) || ((state_reg == ERR) && err_clr);

    t_decoder_run_cnt #(
        .MAX_RUN (MAX_RUN)
    ) u_run_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (run_inc),
        .clr      (run_clr),
        .at_limit (at_limit)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SYNC: if (q_valid) state_next = RUN;
            RUN:  if (at_limit) state_next = ERR;
            ERR:  if (err_clr) state_next = SYNC;
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= SYNC;
            q_prev_reg  <= 1'b0;
            t_out_reg   <= 1'b0;
            t_valid_reg <= 1'b0;
            run_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            t_valid_reg <= accept;
            if (state_reg == SYNC && q_valid) begin
                q_prev_reg <= q_in;
            end
            if (accept) begin
                q_prev_reg <= q_in;
                t_out_reg  <= dec_bit;
            end
            if (at_limit) begin
                run_err_reg <= 1'b1;
            end else if (state_reg == ERR && err_clr) begin
                run_err_reg <= 1'b0;
            end
        end
    end

    assign t_out   = t_out_reg;
    assign t_valid = t_valid_reg;
    assign run_err = run_err_reg;

`ifdef T_DECODER_CNT_EN
    logic [CNT_W-1:0] toggle_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_reg <= '0;
        end else if (accept && dec_bit && (toggle_reg != {CNT_W{1'b1}})) begin
            toggle_reg <= toggle_reg + CNT_W'(1);
        end
    end

    assign toggle_cnt = toggle_reg;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_t_decoder.sv
// Self-checking bench for t_decoder: directed scenarios plus randomized traffic against a behavioural model.
module tb_t_decoder;

    localparam int MAX_RUN = 6;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;
`ifdef T_DECODER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             q_in = 1'b0;
    logic             q_valid = 1'b0;
    logic             err_clr = 1'b0;
    logic             t_out;
    logic             t_valid;
    logic             run_err;
    logic [CNT_W-1:0] toggle_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit m_synced = 0;
    bit m_err    = 0;
    bit m_last   = 0;
    int m_zeros  = 0;
    int m_ones   = 0;
    bit e_tv     = 0;
    bit e_tout   = 0;
    logic [CNT_W-1:0] e_cnt;

    t_decoder #(
        .MAX_RUN (MAX_RUN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .q_valid    (q_valid),
        .err_clr    (err_clr),
        .t_out      (t_out),
        .t_valid    (t_valid),
        .run_err    (run_err),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    // Drives one clock cycle, then advances the model to what the outputs should show after that edge.
    task automatic cycle(input bit r, input bit v, input bit qi, input bit ec);
        bit b;
        rst = r; q_valid = v; q_in = qi; err_clr = ec;
        @(posedge clk);
        #1;
        e_tv = 0;
        if (r) begin
            m_synced = 0; m_err = 0; m_last = 0; m_zeros = 0; m_ones = 0; e_tout = 0;
        end else if (m_err) begin
            if (ec) begin
                m_err = 0; m_synced = 0; m_zeros = 0;
            end
        end else if (v) begin
            if (!m_synced) begin
                m_synced = 1;
                m_last = qi;
            end else begin
                b = qi ^ m_last;
                m_last = qi;
                e_tout = b;
                e_tv = 1;
                if (b) begin
                    m_zeros = 0;
                    if (m_ones < CNT_MAX) m_ones++;
                end else begin
                    m_zeros++;
                    if (m_zeros == MAX_RUN) m_err = 1;
                end
            end
        end
        e_cnt = CNT_EN ? CNT_W'(m_ones) : '0;
        $display("txn rst=%0b qv=%0b qi=%0b clr=%0b -> tv=%0b t=%0b err=%0b cnt=%0d",
                 r, v, qi, ec, t_valid, t_out, run_err, toggle_cnt);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 1, 1);
            checks++;
            if ({t_valid, t_out, run_err, toggle_cnt} !== {1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}}) begin
                errors++;
                $display("FAIL reset: got tv=%0b t=%0b err=%0b cnt=%0d, want all 0",
                         t_valid, t_out, run_err, toggle_cnt);
            end
        end
    endtask

    task automatic test_basic();
        bit seq[5] = '{1, 0, 0, 1, 1};
        bit exp_t[4] = '{1, 0, 1, 0};
        int nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) cycle(0, 1, seq[i], 0);
            else cycle(0, 0, 0, 0);
            checks++;
            if (i == 0 && t_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_sync: t_valid=%0b want 0", t_valid);
            end
            if (t_valid === 1'b1) begin
                if (nv < 4 && t_out !== exp_t[nv]) begin
                    errors++;
                    $display("FAIL basic_bit%0d: t_out=%0b want %0b", nv, t_out, exp_t[nv]);
                end
                nv++;
            end
        end
        checks++;
        if (nv != 4) begin
            errors++;
            $display("FAIL basic_count: t_valid cycles=%0d want 4", nv);
        end
        checks++;
        if (toggle_cnt !== (CNT_EN ? CNT_W'(2) : CNT_W'(0))) begin
            errors++;
            $display("FAIL basic_toggle: toggle_cnt=%0d want %0d", toggle_cnt, CNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_run_err();
        int nzero = 0;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, i < 7, 0, 0);
            checks++;
            if ({t_valid, t_out, run_err, toggle_cnt} !== {e_tv, e_tout, m_err, e_cnt}) begin
                errors++;
                $display("FAIL run_err_cyc%0d: got tv=%0b t=%0b err=%0b cnt=%0d want tv=%0b t=%0b err=%0b cnt=%0d",
                         i, t_valid, t_out, run_err, toggle_cnt, e_tv, e_tout, m_err, e_cnt);
            end
            if (t_valid === 1'b1) nzero++;
            checks++;
            if (run_err !== (nzero >= MAX_RUN)) begin
                errors++;
                $display("FAIL run_err_timing%0d: run_err=%0b after %0d zeros", i, run_err, nzero);
            end
        end
        checks++;
        if (nzero != MAX_RUN) begin
            errors++;
            $display("FAIL run_err_nvalid: decoded zeros=%0d want %0d", nzero, MAX_RUN);
        end
    endtask

    task automatic test_clr_collision();
        cycle(0, 1, 1, 1);
        checks++;
        if (run_err !== 1'b0 || t_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_collision: run_err=%0b t_valid=%0b want 0 0", run_err, t_valid);
        end
        cycle(0, 1, 1, 0);
        checks++;
        if (t_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_sync: t_valid=%0b want 0", t_valid);
        end
        cycle(0, 1, 0, 0);
        checks++;
        if (t_valid !== 1'b1 || t_out !== 1'b1) begin
            errors++;
            $display("FAIL clr_resume: tv=%0b t=%0b want 1 1", t_valid, t_out);
        end
        cycle(0, 0, 0, 1);
        checks++;
        if ({t_valid, t_out, run_err} !== {1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clr_ignored_in_run: tv=%0b t=%0b err=%0b want 0 1 0", t_valid, t_out, run_err);
        end
    endtask

    task automatic test_saturate();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, i[0], 0);
            checks++;
            if ({t_valid, t_out, run_err, toggle_cnt} !== {e_tv, e_tout, m_err, e_cnt}) begin
                errors++;
                $display("FAIL sat_cyc%0d: got tv=%0b t=%0b err=%0b cnt=%0d want tv=%0b t=%0b err=%0b cnt=%0d",
                         i, t_valid, t_out, run_err, toggle_cnt, e_tv, e_tout, m_err, e_cnt);
            end
        end
        checks++;
        if (toggle_cnt !== (CNT_EN ? CNT_W'(7) : CNT_W'(0))) begin
            errors++;
            $display("FAIL sat_final: toggle_cnt=%0d want %0d", toggle_cnt, CNT_EN ? 7 : 0);
        end
    endtask

    task automatic test_mid_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, i[0], 0);
        cycle(1, 1, 1, 0);
        checks++;
        if ({t_valid, t_out, run_err, toggle_cnt} !== {1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}}) begin
            errors++;
            $display("FAIL mid_reset: got tv=%0b t=%0b err=%0b cnt=%0d, want all 0",
                     t_valid, t_out, run_err, toggle_cnt);
        end
        cycle(0, 1, 1, 0);
        checks++;
        if (t_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_sync: t_valid=%0b want 0", t_valid);
        end
    endtask

    task automatic test_gaps();
        int nzero = 0;
        cycle(1, 0, 0, 0);
        for (int s = 0; s < 7; s++) begin
            for (int g = 0; g < 6; g++) begin
                cycle(0, g == 0, 0, 0);
                checks++;
                if ({t_valid, t_out, run_err} !== {e_tv, e_tout, m_err}) begin
                    errors++;
                    $display("FAIL gaps_s%0d_g%0d: got tv=%0b t=%0b err=%0b want tv=%0b t=%0b err=%0b",
                             s, g, t_valid, t_out, run_err, e_tv, e_tout, m_err);
                end
                if (t_valid === 1'b1) nzero++;
            end
        end
        checks++;
        if (nzero != MAX_RUN || run_err !== 1'b1) begin
            errors++;
            $display("FAIL gaps_total: zeros=%0d err=%0b want %0d 1", nzero, run_err, MAX_RUN);
        end
    endtask

    task automatic test_random();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(99) < 2, $urandom_range(99) < 70, $urandom_range(99) < 30,
                  $urandom_range(99) < 15);
            checks++;
            if ({t_valid, t_out, run_err, toggle_cnt} !== {e_tv, e_tout, m_err, e_cnt}) begin
                errors++;
                $display("FAIL random%0d: got tv=%0b t=%0b err=%0b cnt=%0d want tv=%0b t=%0b err=%0b cnt=%0d",
                         i, t_valid, t_out, run_err, toggle_cnt, e_tv, e_tout, m_err, e_cnt);
            end
        end
    endtask

    initial begin
        e_cnt = '0;
        test_reset();
        test_basic();
        test_run_err();
        test_clr_collision();
        test_saturate();
        test_mid_reset();
        test_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
